// File: rtl/set_assoc_wb_cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } cache_state_e;

  localparam int OFFSET_W = 2;
  localparam int DATA_W   = 32;

  // Number of address bits a power-of-two quantity occupies (0 for a count of 1).
  function automatic int field_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of a vector able to hold an index into n items (at least 1 bit).
  function automatic int vec_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_wb_cache_if.sv
// Burst beat interface between the cache (master) and backing memory (slave).
interface set_assoc_wb_cache_if #(
  parameter int ADDR_W = 32
);
  import cache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/set_assoc_wb_cache_lru.sv
// Per-set age-counter LRU: age 0 is most recent, age WAYS-1 is the victim.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  localparam int WAY_W = vec_bits(WAYS),
  localparam int IDX_W = vec_bits(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic             upd_en,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] lru_way
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  // Reset ages to the way number; on access, younger ways age and the accessed way becomes 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way)
          age_q[index][w] <= '0;
        else if (age_q[index][w] < age_q[index][upd_way])
          age_q[index][w] <= age_q[index][w] + WAY_W'(1);
      end
    end
  end

  // The oldest way in the addressed set is the replacement candidate.
  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[index][w] == WAY_W'(WAYS - 1))
        lru_way = WAY_W'(w);
  end

endmodule

// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with burst refill/writeback.
module set_assoc_wb_cache
  import cache_pkg::*;
#(
  parameter int WAYS           = 4,
  parameter int SETS           = 256,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_stall,
  set_assoc_wb_cache_if.master mem
);

  localparam int WORD_BITS = field_bits(WORDS_PER_LINE);
  localparam int IDX_BITS  = field_bits(SETS);
  localparam int BEAT_W    = vec_bits(WORDS_PER_LINE);
  localparam int IDX_W     = vec_bits(SETS);
  localparam int WAY_W     = vec_bits(WAYS);
  localparam int TAG_LSB   = OFFSET_W + WORD_BITS + IDX_BITS;
  localparam int TAG_W     = ADDR_W - TAG_LSB;

  logic [BEAT_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  // Single-entry fields collapse to constant zero.
  assign req_word = (WORD_BITS == 0) ? '0 : BEAT_W'(cpu_addr >> OFFSET_W);
  assign req_idx  = (IDX_BITS == 0)  ? '0 : IDX_W'(cpu_addr >> (OFFSET_W + WORD_BITS));
  assign req_tag  = TAG_W'(cpu_addr >> TAG_LSB);

  logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];

  cache_state_e      state_q, state_n;
  logic [WAY_W-1:0]  victim_q;
  logic [BEAT_W-1:0] beat_q;
  logic              mem_req_q, mem_we_q;

  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  victim_sel;
  logic              found_inv;
  logic              hit_access;
  logic              beat_ok;
  logic              last_beat;
  logic              refill_done;
  logic [TAG_W-1:0]  line_tag;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w])
        hit_way = WAY_W'(w);
    end
  end

  assign hit = |hit_vec;

  // Prefer the lowest-numbered empty way; otherwise replace the LRU way.
  always_comb begin
    victim_sel = lru_way;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][req_idx]) begin
        victim_sel = WAY_W'(w);
        found_inv  = 1'b1;
      end
    end
  end

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .index   (req_idx),
    .upd_en  (hit_access),
    .upd_way (hit_way),
    .lru_way (lru_way)
  );

  assign beat_ok     = mem_req_q && mem.mem_ready;
  assign last_beat   = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
  assign refill_done = (state_q == REFILL) && beat_ok && last_beat;

  // Next-state and stall logic; only IDLE hits complete an access.
  always_comb begin
    state_n    = state_q;
    cpu_stall  = 1'b0;
    hit_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            hit_access = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
              state_n = WRITEBACK;
            else
              state_n = REFILL;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall = cpu_req;
        if (beat_ok && last_beat)
          state_n = REFILL;
      end
      REFILL: begin
        cpu_stall = cpu_req;
        if (beat_ok && last_beat)
          state_n = DONE;
      end
      DONE: begin
        cpu_stall = cpu_req;
        state_n   = IDLE;
      end
    endcase
  end

  // State, victim latch, beat counter and registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      victim_q  <= '0;
      beat_q    <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      mem_req_q <= (state_n == WRITEBACK) || (state_n == REFILL);
      mem_we_q  <= (state_n == WRITEBACK);
      if (state_q == IDLE && cpu_req && !hit)
        victim_q <= victim_sel;
      if ((state_q == WRITEBACK || state_q == REFILL) && beat_ok)
        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Line status: stores mark dirty, a completed refill installs a clean valid line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      if (hit_access && cpu_we)
        dirty_q[hit_way][req_idx] <= 1'b1;
      if (refill_done) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
    end
  end

  // Tag array is not reset; it is only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (refill_done)
      tag_q[victim_q][req_idx] <= req_tag;
  end

  // Data array: store hits and refill beats never target the same cycle.
  always_ff @(posedge clk) begin
    if (hit_access && cpu_we)
      data_q[hit_way][req_idx][req_word] <= cpu_wdata;
    else if (state_q == REFILL && beat_ok)
      data_q[victim_q][req_idx][beat_q] <= mem.mem_rdata;
  end

  assign line_tag = mem_we_q ? tag_q[victim_q][req_idx] : req_tag;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = (ADDR_W'(line_tag) << TAG_LSB)
                       | (ADDR_W'(req_idx) << (OFFSET_W + WORD_BITS))
                       | (ADDR_W'(beat_q) << OFFSET_W);
  assign mem.mem_wdata = data_q[victim_q][req_idx][beat_q];

  assign cpu_rdata = (state_q == IDLE && cpu_req && !cpu_we && hit)
                   ? data_q[hit_way][req_idx][req_word] : '0;

endmodule
